// File: rtl/prescaler_mc.sv
// Multi-channel event prescaler: per channel, one event_o pulse per (presc+1) events,
// with shadowed reload at terminal count, one-shot mode, toggle level and count readback.

module prescaler_mc_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             active,
  input  logic             update,
  input  logic             crst,
  input  logic [CNT_W-1:0] presc,
  input  logic             sync_upd,
  input  logic             oneshot,
  input  logic             ev_in,
  output logic             ev_out,
  output logic             level,
  output logic [CNT_W-1:0] counter,
  output logic             pending
);
  logic [CNT_W-1:0] r_presc, shadow;
  logic             done;
  logic             upd_imm;

  // An update can only be deferred while the channel is actually counting.
  assign upd_imm = !sync_upd || !active || crst;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc <= '0;
      shadow  <= '0;
      counter <= '0;
      ev_out  <= 1'b0;
      level   <= 1'b0;
      done    <= 1'b0;
      pending <= 1'b0;
    end else begin
      ev_out <= 1'b0;
      if (crst) begin
        counter <= '0;
        level   <= 1'b0;
        done    <= 1'b0;
        if (pending && !update) begin
          r_presc <= shadow;
          pending <= 1'b0;
        end
      end else if (!active) begin
        counter <= '0;
        done    <= 1'b0;
        if (pending) begin
          r_presc <= shadow;
          pending <= 1'b0;
        end
      end else if (ev_in && !done) begin
        // ">=" so a reload below the current count fires instead of wrapping.
        if (counter >= r_presc) begin
          ev_out  <= 1'b1;
          counter <= '0;
          level   <= ~level;
          done    <= oneshot;
          if (pending) begin
            r_presc <= shadow;
            pending <= 1'b0;
          end
        end else begin
          counter <= counter + 1'b1;
        end
      end
      // A new request overrides whatever the count path did to the reload state.
      if (update) begin
        if (upd_imm) begin
          r_presc <= presc;
          pending <= 1'b0;
        end else begin
          shadow  <= presc;
          pending <= 1'b1;
        end
      end
    end
  end
endmodule

module prescaler_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       ctrl_active_i,
  input  logic [NUM_CH-1:0]       ctrl_update_i,
  input  logic [NUM_CH-1:0]       ctrl_rst_i,
  input  logic [NUM_CH*CNT_W-1:0] cfg_presc_i,
  input  logic [NUM_CH-1:0]       cfg_sync_upd_i,
  input  logic [NUM_CH-1:0]       cfg_oneshot_i,
  input  logic [NUM_CH-1:0]       event_i,
  output logic [NUM_CH-1:0]       event_o,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH*CNT_W-1:0] counter_o,
  output logic [NUM_CH-1:0]       upd_pending_o
);
  logic [NUM_CH-1:0][CNT_W-1:0] presc, cnt;

  assign presc     = cfg_presc_i;
  assign counter_o = cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    prescaler_mc_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .active   (ctrl_active_i[c]),
      .update   (ctrl_update_i[c]),
      .crst     (ctrl_rst_i[c]),
      .presc    (presc[c]),
      .sync_upd (cfg_sync_upd_i[c]),
      .oneshot  (cfg_oneshot_i[c]),
      .ev_in    (event_i[c]),
      .ev_out   (event_o[c]),
      .level    (level_o[c]),
      .counter  (cnt[c]),
      .pending  (upd_pending_o[c])
    );
  end
endmodule
